// File: rtl/count_step_monitor_pkg.sv
// Shared definitions for the count step monitor: FSM encoding and
// direction constants.
package count_step_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // no reference sample captured yet
        ST_TRACK = 2'd1,   // following a legal count stream
        ST_FAULT = 2'd2    // last non-stall step was illegal
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage : count_step_monitor_pkg

// File: rtl/count_step_monitor_if.sv
// Observed counter stream: the counter (master) drives its count and a
// qualifying strobe, and the monitor (slave) samples them.
interface count_step_monitor_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] cnt_in;
    logic             cnt_valid;

    modport master (output cnt_in, output cnt_valid);
    modport slave  (input  cnt_in, input  cnt_valid);
endinterface : count_step_monitor_if

// File: rtl/count_step_monitor_sat_counter.sv
// Saturating up counter with synchronous clear and load-of-one.
// Priority: reset/clear, then load-1, then increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load1,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Counter register; updates on the falling edge alongside the observed counter.
    always_ff @(negedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset || clr) begin
            count <= '0;
        end else if (load1) begin
            count <= W'(1);
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule : sat_counter

// File: rtl/count_step_monitor.sv
// Receives an up/down counter's output, recovers the count direction and
// flags wrap-around and illegal steps. All outputs are registered and
// change on the falling edge that samples cnt_valid=1.
module count_step_monitor
    import count_step_monitor_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int RUN_W = 8,
    parameter int ERR_W = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    count_step_monitor_if.slave       bus,
    output logic                      dir,
    output logic                      dir_valid,
    output logic                      wrap,
    output logic                      step_err,
    output logic [RUN_W-1:0]          run_len,
    output logic [ERR_W-1:0]          err_cnt
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             dir_d, dir_valid_d, wrap_d, step_err_d;
    logic             run_clr, run_load, run_inc;
    logic             err_inc;

    logic [WIDTH-1:0] cnt_in;
    logic             cnt_valid;
    logic [WIDTH-1:0] delta;
    logic             step_up, step_down, step_stall;

    assign cnt_in    = bus.cnt_in;
    assign cnt_valid = bus.cnt_valid;

    // Modular step; with WIDTH=1 a delta of 1 is also all-ones and is taken as up.
    assign delta      = cnt_in - prev_q;
    assign step_up    = (delta == ONE);
    assign step_down  = (delta == ALL_ONES) && !step_up;
    assign step_stall = (delta == '0);

    // Next-state and next-output decode for the step classifier.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        prev_d      = prev_q;
        dir_d       = dir;
        dir_valid_d = dir_valid;
        wrap_d      = 1'b0;
        step_err_d  = 1'b0;
        run_clr     = 1'b0;
        run_load    = 1'b0;
        run_inc     = 1'b0;
        err_inc     = 1'b0;

        if (cnt_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    prev_d  = cnt_in;
                    state_d = ST_TRACK;
                end
                ST_TRACK, ST_FAULT: begin
                    if (step_up) begin
                        run_inc     = dir_valid && (dir == DIR_UP);
                        run_load    = !run_inc;
                        dir_d       = DIR_UP;
                        dir_valid_d = 1'b1;
                        wrap_d      = (prev_q == ALL_ONES) && (cnt_in == '0);
                        prev_d      = cnt_in;
                        state_d     = ST_TRACK;
                    end else if (step_down) begin
                        run_inc     = dir_valid && (dir == DIR_DOWN);
                        run_load    = !run_inc;
                        dir_d       = DIR_DOWN;
                        dir_valid_d = 1'b1;
                        wrap_d      = (prev_q == '0) && (cnt_in == ALL_ONES);
                        prev_d      = cnt_in;
                        state_d     = ST_TRACK;
                    end else if (!step_stall) begin
                        step_err_d  = 1'b1;
                        err_inc     = 1'b1;
                        dir_valid_d = 1'b0;
                        run_clr     = 1'b1;
                        prev_d      = cnt_in;
                        state_d     = ST_FAULT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, reference sample and single-bit status registers.
    always_ff @(negedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            prev_q    <= '0;
            dir       <= DIR_DOWN;
            dir_valid <= 1'b0;
            wrap      <= 1'b0;
            step_err  <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            dir       <= dir_d;
            dir_valid <= dir_valid_d;
            wrap      <= wrap_d;
            step_err  <= step_err_d;
        end
    end

    sat_counter #(.W(RUN_W)) u_run_len (
        .clk   (clk),
        .reset (reset),
        .clr   (run_clr),
        .load1 (run_load),
        .inc   (run_inc),
        .count (run_len)
    );

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .load1 (1'b0),
        .inc   (err_inc),
        .count (err_cnt)
    );

endmodule : count_step_monitor

// File: tb/tb_count_step_monitor.sv
// Self-checking bench for count_step_monitor: directed scenarios followed
// by randomized traffic, compared against a modular-arithmetic model.
module tb_count_step_monitor;

    localparam int WIDTH   = 4;
    localparam int RUN_W   = 8;
    localparam int ERR_W   = 4;
    localparam int MOD     = 1 << WIDTH;
    localparam int RUN_MAX = (1 << RUN_W) - 1;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic             clk = 1'b1;
    logic             reset;
    logic             dir, dir_valid, wrap, step_err;
    logic [RUN_W-1:0] run_len;
    logic [ERR_W-1:0] err_cnt;

    count_step_monitor_if #(.WIDTH(WIDTH)) bus ();

    count_step_monitor #(.WIDTH(WIDTH), .RUN_W(RUN_W), .ERR_W(ERR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .dir       (dir),
        .dir_valid (dir_valid),
        .wrap      (wrap),
        .step_err  (step_err),
        .run_len   (run_len),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int wraps = 0;

    // Reference model state: what the monitor should present.
    bit m_have;
    int m_prev, m_dir, m_dv, m_run, m_err, m_wrap, m_serr;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit v, input int val);
        int d;
        m_wrap = 0;
        m_serr = 0;
        if (r) begin
            m_have = 0; m_prev = 0; m_dir = 0; m_dv = 0; m_run = 0; m_err = 0;
        end else if (v) begin
            if (!m_have) begin
                m_have = 1;
                m_prev = val;
            end else begin
                d = ((val - m_prev) % MOD + MOD) % MOD;
                if (d == 1) begin
                    m_run  = (m_dv == 1 && m_dir == 1) ? ((m_run < RUN_MAX) ? m_run + 1 : RUN_MAX) : 1;
                    m_dir  = 1;
                    m_dv   = 1;
                    m_wrap = (m_prev == MOD - 1 && val == 0) ? 1 : 0;
                    m_prev = val;
                end else if (d == MOD - 1) begin
                    m_run  = (m_dv == 1 && m_dir == 0) ? ((m_run < RUN_MAX) ? m_run + 1 : RUN_MAX) : 1;
                    m_dir  = 0;
                    m_dv   = 1;
                    m_wrap = (m_prev == 0 && val == MOD - 1) ? 1 : 0;
                    m_prev = val;
                end else if (d != 0) begin
                    m_serr = 1;
                    m_err  = (m_err < ERR_MAX) ? m_err + 1 : ERR_MAX;
                    m_dv   = 0;
                    m_run  = 0;
                    m_prev = val;
                end
            end
        end
    endtask

    // Drive one edge's inputs, let the falling edge act, then compare all outputs.
    task automatic cycle(input bit r, input bit v, input int val);
        reset         = r;
        bus.cnt_valid = v;
        bus.cnt_in    = WIDTH'(val);
        @(negedge clk);
        #1;
        model_step(r, v, val);
        if (wrap) wraps++;
        chk("dir",       int'(dir),       m_dir);
        chk("dir_valid", int'(dir_valid), m_dv);
        chk("wrap",      int'(wrap),      m_wrap);
        chk("step_err",  int'(step_err),  m_serr);
        chk("run_len",   int'(run_len),   m_run);
        chk("err_cnt",   int'(err_cnt),   m_err);
    endtask

    task automatic sample(input int val);
        cycle(1'b0, 1'b1, val);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 0);
    endtask

    initial begin
        int choice, val;
        reset         = 1'b1;
        bus.cnt_valid = 1'b0;
        bus.cnt_in    = '0;

        // Reset state.
        do_reset();
        do_reset();
        chk("reset_run_len", int'(run_len), 0);
        chk("reset_dir_valid", int'(dir_valid), 0);

        // Reset mid-run wins over a valid sample; next sample only seeds.
        for (int i = 0; i < 4; i++) sample(i);
        cycle(1'b1, 1'b1, 4);
        chk("midrst_run_len", int'(run_len), 0);
        chk("midrst_dir", int'(dir), 0);
        sample(7);
        chk("reseed_dir_valid", int'(dir_valid), 0);
        chk("reseed_run_len", int'(run_len), 0);

        // Up sequence through the wrap point.
        do_reset();
        wraps = 0;
        for (int i = 0; i < 18; i++) begin
            sample(i % MOD);
            if (i == 1) chk("up_dir_valid_2nd", int'(dir_valid), 1);
        end
        chk("up_wrap_count", wraps, 1);
        chk("up_run_len_17", int'(run_len), 17);
        chk("up_dir", int'(dir), 1);

        // Down sequence through the wrap point.
        do_reset();
        wraps = 0;
        sample(2); sample(1); sample(0);
        sample(15);
        chk("down_wrap", int'(wrap), 1);
        sample(14);
        chk("down_run_len_4", int'(run_len), 4);
        chk("down_dir", int'(dir), 0);
        chk("down_wrap_count", wraps, 1);

        // Direction reversal.
        do_reset();
        sample(5); sample(6); sample(7);
        chk("rev_run_at_7", int'(run_len), 2);
        sample(6);
        chk("rev_run_at_6", int'(run_len), 1);
        chk("rev_dir_at_6", int'(dir), 0);
        sample(5);
        chk("rev_step_err", int'(step_err), 0);

        // Illegal jump and recovery.
        do_reset();
        sample(3); sample(4); sample(9);
        chk("jump_step_err", int'(step_err), 1);
        chk("jump_err_cnt", int'(err_cnt), 1);
        chk("jump_dir_valid", int'(dir_valid), 0);
        sample(10);
        chk("recover_dir", int'(dir), 1);
        chk("recover_run_len", int'(run_len), 1);
        chk("recover_step_err", int'(step_err), 0);

        // Stall and gaps leave run length untouched.
        do_reset();
        sample(3); sample(4); sample(4);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 9);
        chk("gap_run_len", int'(run_len), 1);
        sample(5);
        chk("gap_run_len_after", int'(run_len), 2);
        chk("gap_err_cnt", int'(err_cnt), 0);

        // Error counter saturation.
        do_reset();
        sample(0);
        for (int i = 1; i <= 17; i++) sample((2 * i) % MOD);
        chk("err_sat", int'(err_cnt), ERR_MAX);

        // Run-length saturation.
        do_reset();
        for (int i = 0; i < 270; i++) sample(i % MOD);
        chk("run_sat", int'(run_len), RUN_MAX);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            choice = int'($urandom_range(0, 19));
            if (choice == 0) begin
                cycle(1'b1, $urandom_range(0, 1) == 1, int'($urandom_range(0, MOD - 1)));
            end else if (choice < 4) begin
                cycle(1'b0, 1'b0, int'($urandom_range(0, MOD - 1)));
            end else begin
                if (choice < 10)      val = m_prev + 1;
                else if (choice < 15) val = m_prev + MOD - 1;
                else if (choice < 17) val = m_prev;
                else                  val = int'($urandom_range(0, MOD - 1));
                sample(val % MOD);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_count_step_monitor
